fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS pipeline: holds the program counter, drives it to the instruction memory, and captures the returned word into the IF/ID pipeline register. It sits directly upstream of the instruction memory and feeds the decode stage. It handles stall, flush and branch/jump redirects, detects a halt word, and traps misaligned redirect targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `stall` input, 1 bit: hold PC and IF/ID contents.
- `flush` input, 1 bit: invalidate IF/ID; PC continues sequentially.
- `branch_taken` input, 1 bit: redirect to `branch_target`.
- `branch_target` input, 32 bits: branch destination (byte address).
- `jump` input, 1 bit: redirect to `jump_target`.
- `jump_target` input, 32 bits: jump destination (byte address).
- `pc` output, 32 bits: registered fetch address to the instruction memory.
- `inst_in` input, 32 bits: combinational instruction word returned for `pc`.
- `ifid_inst` output, 32 bits: latched instruction.
- `ifid_pc4` output, 32 bits: `pc`+4 of the latched instruction.
- `ifid_valid` output, 1 bit: IF/ID holds a live instruction.
- `halted` output, 1 bit: high in HALT state.
- `fault` output, 1 bit: high in FAULT state (sticky until reset).
- `fetch_cnt` output, 32 bits: present only with `FETCH_PERF_CNT_EN`.
- `stall_cnt` output, 16 bits: present only with `FETCH_PERF_CNT_EN`.

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset (asynchronous) forces:
  - state = BOOT, `pc` = `RESET_PC`;
  - `ifid_inst` = 0, `ifid_pc4` = 0, `ifid_valid` = 0;
  - `halted` = 0, `fault` = 0, counters = 0.
- BOOT: lasts one cycle. `ifid_valid` stays 0 and `pc` holds. Next state is RUN.
- Priority in RUN, evaluated each edge:
  1. Redirect: `branch_taken`, or else `jump`. `branch_taken` wins when both are high.
     - Target[1:0] ≠ 0 → FAULT. `pc` holds and `ifid_valid` ← 0.
     - Aligned target → `pc` ← target, `ifid_valid` ← 0.
  2. `flush` → `ifid_valid` ← 0 and `pc` ← `pc`+4.
  3. `stall` → `pc`, `ifid_*` and state all hold.
  4. Normal fetch → `ifid_inst` ← `inst_in`, `ifid_pc4` ← `pc`+4, `ifid_valid` ← 1.
     - `inst_in` ≠ `HALT_WORD` → `pc` ← `pc`+4.
     - `inst_in` = `HALT_WORD` → the halt word is latched valid, `pc` holds, next state is HALT.
- Redirect and flush take precedence over `stall` in the same cycle.
- HALT:
  - `halted` = 1; `ifid_valid` ← 0 from the cycle after entry.
  - `stall` and `flush` are ignored.
  - An aligned redirect returns to RUN with `pc` ← target.
  - A misaligned redirect → FAULT.
- FAULT: all outputs hold except `ifid_valid` = 0 and `fault` = 1. Only reset exits FAULT.
- Arithmetic: `pc`+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC wraps to 0. The memory decodes only `pc[15:0]`, so the upper bits are don't-care to it.

## Timing
- `pc` changes only on a `clk` edge (or asynchronously on reset).
- `inst_in` is valid combinationally in the same cycle as `pc`.
- Fetch latency: the word at `pc` in cycle N appears on `ifid_inst` in cycle N+1.
- Redirect asserted in cycle N:
  - `pc` = target in N+1, and `ifid_valid` = 0 in N+1;
  - the target instruction is valid in IF/ID in N+2;
  - one bubble per redirect.
- Reset deasserted before edge E: BOOT covers cycle E; the first valid IF/ID (instruction at `RESET_PC`) appears after edge E+2.
- Reset mid-operation: all state clears immediately without waiting for a clock; in-flight instructions are lost.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds `fetch_cnt` and `stall_cnt`.
  - `fetch_cnt` increments on every edge that loads IF/ID with `ifid_valid` ← 1, including the halt word. It wraps at 2^32.
  - `stall_cnt` increments on every RUN-state edge where `stall` wins priority. It saturates at 16'hFFFF.
  - Both counters clear on reset.
- `FETCH_PERF_CNT_EN` undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0 and memory words 0x2001_0005 at 0 and 0x2002_0003 at 4 → one BOOT bubble, then `ifid_inst` = 0x2001_0005 with `ifid_pc4` = 4, then 0x2002_0003 with `ifid_pc4` = 8.
- `stall` held 3 cycles mid-stream → `pc` and `ifid_*` frozen for 3 cycles; resumes without loss or duplication; `stall_cnt` = 3.
- `branch_taken` with target 0x40 while `jump` targets 0x80 in the same cycle → `pc` = 0x40 next cycle, one bubble, then the word at 0x40 valid.
- `flush` and `stall` together → `ifid_valid` = 0 and `pc` advances by 4.
- `HALT_WORD` at 0x0C → `ifid_inst` = FFFF_FFFF valid once, `halted` = 1, `pc` stays 0x0C; a later jump to 0x00 resumes RUN.
- Jump to 0x0000_0006 → `fault` = 1, `ifid_valid` = 0, fetch frozen; asynchronous `rst_n` pulse clears `fault` and `pc` = `RESET_PC` immediately.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: control from the hazard unit, the PC/instruction pair to the memory, and the IF/ID register to decode.
// The fetch_cnt/stall_cnt members exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    // Handshake: ifid_valid qualifies ifid_inst/ifid_pc4 every cycle; stall is the
    // consumer's backpressure and, while it wins priority, freezes pc and the whole IF/ID
    // register so a valid word stays presented until a non-stalled edge accepts it.
    // inst_in has no handshake: the memory answers combinationally for the current pc.
    modport master (
`ifdef FETCH_PERF_CNT_EN
        output fetch_cnt, output stall_cnt,
`endif
        input  stall, input flush, input branch_taken, input branch_target,
        input  jump, input jump_target, input inst_in,
        output pc, output ifid_inst, output ifid_pc4, output ifid_valid,
        output halted, output fault, output state_dbg
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  fetch_cnt, input stall_cnt,
`endif
        output stall, output flush, output branch_taken, output branch_target,
        output jump, output jump_target, output inst_in,
        input  pc, input ifid_inst, input ifid_pc4, input ifid_valid,
        input  halted, input fault, input state_dbg
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, redirect/stall/flush handling, halt and misalignment trap.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_next;
    logic        boot_armed_q;
    logic [31:0] pc_q, pc_next;
    logic [31:0] inst_q, inst_next;
    logic [31:0] pc4_q, pc4_next;
    logic        valid_q, valid_next;

    logic        redirect;
    logic [31:0] target;
    logic        target_misaligned;
    logic [31:0] pc_plus4;

    assign redirect          = bus.branch_taken | bus.jump;
    assign target            = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign target_misaligned = |target[1:0];
    assign pc_plus4          = pc_q + 32'd4;

    // The first edge after reset release only arms BOOT, so BOOT spans one full clock cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            boot_armed_q <= 1'b0;
        end else begin
            state_q      <= state_next;
            boot_armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        inst_next  = inst_q;
        pc4_next   = pc4_q;
        valid_next = valid_q;
        case (state_q)
            BOOT: begin
                valid_next = 1'b0;
                if (boot_armed_q) state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    if (target_misaligned) state_next = FAULT;
                    else                   pc_next    = target;
                end else if (bus.flush) begin
                    valid_next = 1'b0;
                    pc_next    = pc_plus4;
                end else if (!bus.stall) begin
                    inst_next  = bus.inst_in;
                    pc4_next   = pc_plus4;
                    valid_next = 1'b1;
                    if (bus.inst_in == HALT_WORD) state_next = HALT;
                    else                          pc_next    = pc_plus4;
                end
            end
            HALT: begin
                valid_next = 1'b0;
                if (redirect) begin
                    if (target_misaligned) begin
                        state_next = FAULT;
                    end else begin
                        pc_next    = target;
                        state_next = RUN;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.halted    = (state_q == HALT);
        bus.fault     = (state_q == FAULT);
        bus.state_dbg = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            inst_q  <= inst_next;
            pc4_q   <= pc4_next;
            valid_q <= valid_next;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ifid_inst  = inst_q;
    assign bus.ifid_pc4   = pc4_q;
    assign bus.ifid_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_evt;
    logic        stall_evt;
    logic [31:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    assign fetch_evt = (state_q == RUN) & ~redirect & ~bus.flush & ~bus.stall;
    assign stall_evt = (state_q == RUN) & ~redirect & ~bus.flush &  bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 16'h0;
        end else begin
            if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, then random
// stimulus against a behavioural model of the fetch stage.
module tb_fetch_unit;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:255];
  assign bus.inst_in = mem[bus.pc[9:2]];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    bus.stall = s; bus.flush = f;
    bus.branch_taken = b; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid, m_halted, m_fault;
  int          m_boot;
  logic [31:0] m_fetch;
  int          m_stall;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    m_boot = 2; m_fetch = 32'h0; m_stall = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply one cycle of inputs at a negedge; model and DUT both advance on the posedge.
  task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic [31:0] word, tgt;
    logic        loaded;
    loaded = 1'b0;
    drive(s, f, b, bt, j, jt);
    word = mem[m_pc[9:2]];
    if (m_boot > 0) begin
      m_boot--;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (b || j) begin
      tgt = b ? bt : jt;
      m_valid = 1'b0;
      if ((tgt & 32'h3) != 32'h0) begin
        m_fault = 1'b1; m_halted = 1'b0;
      end else begin
        m_pc = tgt; m_halted = 1'b0;
      end
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (f) begin
      m_valid = 1'b0;
      m_pc = m_pc + 32'd4;
    end else if (s) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_inst = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_fetch = m_fetch + 32'd1;
      exp_q.push_back(word);
      loaded = 1'b1;
      if (word == HALT_W) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    chk("pc", bus.pc, m_pc);
    chk("ifid_inst", bus.ifid_inst, m_inst);
    chk("ifid_pc4", bus.ifid_pc4, m_pc4);
    chk("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, bus.halted}, {31'h0, m_halted});
    chk("fault", {31'h0, bus.fault}, {31'h0, m_fault});
    if (loaded) chk("stream", bus.ifid_inst, exp_q.pop_front());
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", bus.fetch_cnt, m_fetch);
    chk("stall_cnt", {16'h0, bus.stall_cnt}, m_stall);
`endif
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic s, f, b; logic [31:0] bt; logic j; logic [31:0] jt;
    logic [31:0] e_pc, e_inst, e_pc4; logic e_valid, e_halted, e_fault;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_pc4, input logic e_valid,
                              input logic e_halted, input logic e_fault);
    vec_t v;
    v.s = s; v.f = f; v.b = b; v.bt = bt; v.j = j; v.jt = jt;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_halted = e_halted; v.e_fault = e_fault;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_0003;
    mem[3]  = HALT_W;
    mem[16] = 32'h2400_0040;
    mem[255] = 32'h1000_00FF;

    //          s f b  bt     j  jt       pc      inst          pc4    v h f
    tbl[0]  = mk(0,0,0,32'h0, 0,32'h0,  32'h00, 32'h0,        32'h0,  0,0,0); // BOOT
    tbl[1]  = mk(0,0,0,32'h0, 0,32'h0,  32'h00, 32'h0,        32'h0,  0,0,0); // first RUN cycle
    tbl[2]  = mk(0,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 1,0,0);
    tbl[3]  = mk(1,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 1,0,0);
    tbl[4]  = mk(1,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 1,0,0);
    tbl[5]  = mk(1,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 1,0,0);
    tbl[6]  = mk(0,0,0,32'h0, 0,32'h0,  32'h08, 32'h2002_0003,32'h08, 1,0,0);
    tbl[7]  = mk(0,0,1,32'h40,1,32'h80, 32'h40, 32'h2002_0003,32'h08, 0,0,0); // branch beats jump
    tbl[8]  = mk(0,0,0,32'h0, 0,32'h0,  32'h44, 32'h2400_0040,32'h44, 1,0,0);
    tbl[9]  = mk(1,1,0,32'h0, 0,32'h0,  32'h48, 32'h2400_0040,32'h44, 0,0,0); // flush beats stall
    tbl[10] = mk(0,0,0,32'h0, 0,32'h0,  32'h4C, 32'h1000_0012,32'h4C, 1,0,0);
    tbl[11] = mk(0,0,0,32'h0, 1,32'h08, 32'h08, 32'h1000_0012,32'h4C, 0,0,0);
    tbl[12] = mk(0,0,0,32'h0, 0,32'h0,  32'h0C, 32'h1000_0002,32'h0C, 1,0,0);
    tbl[13] = mk(0,0,0,32'h0, 0,32'h0,  32'h0C, HALT_W,       32'h10, 1,1,0); // halt word latched
    tbl[14] = mk(1,1,0,32'h0, 0,32'h0,  32'h0C, HALT_W,       32'h10, 0,1,0); // stall/flush ignored
    tbl[15] = mk(0,0,0,32'h0, 1,32'h00, 32'h00, HALT_W,       32'h10, 0,0,0); // resume
    tbl[16] = mk(0,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 1,0,0);
    tbl[17] = mk(0,0,0,32'h0, 1,32'h06, 32'h04, 32'h2001_0005,32'h04, 0,0,1); // misaligned
    tbl[18] = mk(1,0,0,32'h0, 0,32'h0,  32'h04, 32'h2001_0005,32'h04, 0,0,1);
    tbl[19] = mk(0,0,1,32'h20,0,32'h0,  32'h04, 32'h2001_0005,32'h04, 0,0,1); // FAULT is sticky

    #12;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_inst", bus.ifid_inst, 32'h0);
    chk("rst_pc4", bus.ifid_pc4, 32'h0);
    chk("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
    chk("rst_halted", {31'h0, bus.halted}, 32'h0);
    chk("rst_fault", {31'h0, bus.fault}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_pc", i), bus.pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), bus.ifid_inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_pc4", i), bus.ifid_pc4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d_valid", i), {31'h0, bus.ifid_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_halted", i), {31'h0, bus.halted}, {31'h0, tbl[i].e_halted});
      chk($sformatf("tbl%0d_fault", i), {31'h0, bus.fault}, {31'h0, tbl[i].e_fault});
`ifdef FETCH_PERF_CNT_EN
      if (i == 5) chk("stall_cnt_after_3", {16'h0, bus.stall_cnt}, 32'd3);
`endif
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("tbl_fetch_cnt", bus.fetch_cnt, 32'd7);
    chk("tbl_stall_cnt", {16'h0, bus.stall_cnt}, 32'd3);
`endif

    // Asynchronous reset out of FAULT, checked before any clock edge arrives.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_fault", {31'h0, bus.fault}, 32'h0);
    chk("async_valid", {31'h0, bus.ifid_valid}, 32'h0);
    chk("async_inst", bus.ifid_inst, 32'h0);
    chk("async_pc4", bus.ifid_pc4, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Hand sequence: PC wrap at the top of the address space, then halt and a misaligned
    // branch taken from HALT.
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,1,32'hFFFF_FFFC);
    step(0,0,0,32'h0,0,32'h0);
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,1,32'h0C);
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,0,32'h0);
    step(0,0,1,32'h41,0,32'h0);
    chk("halt_to_fault", {31'h0, bus.fault}, 32'h1);
    step(0,0,0,32'h0,0,32'h0);

    // Randomized phase.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? HALT_W : $urandom;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic s, f, b, j;
      logic [31:0] bt, jt;
      int r;
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 11) == 0);
      j = ($urandom_range(0, 11) == 0);
      bt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      jt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      r = $urandom_range(0, 19);
      if (r == 0) bt = $urandom | 32'h1;
      if (r == 1) jt = $urandom | 32'h2;
      if (r == 2) jt = 32'hFFFF_FFFC;
      step(s, f, b, bt, j, jt);
      if (m_fault && ($urandom_range(0, 3) == 0)) do_reset();
      else if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
